// File: rtl/quad_step_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : quad_step_decoder
//  Description : Quadrature (A/B) encoder decoder. Synchronizes and debounces
//                both channels, then emits one-cycle step pulses with a
//                direction level, a wrapping position count, and flags
//                illegal (both-channel) transitions with a saturating count.
//  Revision    : 1.0 - initial release
// ============================================================================
module quad_step_decoder #(
    parameter int FILTER_LEN = 4,
    parameter int POS_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_a,
    input  logic             enc_b,
    output logic             enable,
    output logic             up_down,
    output logic [POS_W-1:0] position,
    output logic             err,
    output logic [3:0]       err_cnt
);

    // Filter terminal count and last cycle of the post-reset settling window.
    localparam logic [3:0] c_flt_lim   = 4'(FILTER_LEN - 1);
    localparam logic [4:0] c_init_last = 5'(FILTER_LEN + 1);

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    // Channel bit 1 is A, bit 0 is B throughout.
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       w_filt;
    logic [1:0]       r_prev;
    logic [1:0]       w_prev_nxt;
    logic [4:0]       r_init_cnt;
    logic             w_init_load;

    logic             r_enable;
    logic             r_err;
    logic             r_up_down;
    logic [POS_W-1:0] r_pos;
    logic [3:0]       r_errc;
    logic             w_enable_nxt;
    logic             w_err_nxt;
    logic             w_dir_nxt;
    logic [POS_W-1:0] w_pos_nxt;
    logic [3:0]       w_errc_nxt;

    assign w_init_load = (r_state == S_INIT) && (r_init_cnt == c_init_last);

    // Two-flop synchronizer for the asynchronous encoder pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= {enc_a, enc_b};
            r_sync2 <= r_sync1;
        end
    end

    // Per-channel debounce: a new level must persist FILTER_LEN cycles.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_filter
            logic [3:0] r_cnt;
            logic       r_val;

            // Counter/filtered value; held idle during settling, loaded at its end.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_cnt <= 4'd0;
                    r_val <= 1'b0;
                end else if (r_state == S_INIT) begin
                    r_cnt <= 4'd0;
                    if (w_init_load) begin
                        r_val <= r_sync2[gi];
                    end
                end else if (r_sync2[gi] == r_val) begin
                    r_cnt <= 4'd0;
                end else if (r_cnt == c_flt_lim) begin
                    r_val <= r_sync2[gi];
                    r_cnt <= 4'd0;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end

            assign w_filt[gi] = r_val;
        end
    endgenerate

    // Settling window counter: lets the synchronizer fill before the
    // encoder state is adopted, so reset never produces a spurious step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_init_cnt <= 5'd0;
        end else if ((r_state == S_INIT) && (r_init_cnt != c_init_last)) begin
            r_init_cnt <= r_init_cnt + 5'd1;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_INIT;
            r_prev    <= 2'b00;
            r_enable  <= 1'b0;
            r_err     <= 1'b0;
            r_up_down <= 1'b0;
            r_pos     <= '0;
            r_errc    <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_prev    <= w_prev_nxt;
            r_enable  <= w_enable_nxt;
            r_err     <= w_err_nxt;
            r_up_down <= w_dir_nxt;
            r_pos     <= w_pos_nxt;
            r_errc    <= w_errc_nxt;
        end
    end

    // Next state and transition classification of {prev, filtered}.
    always_comb begin
        w_state_nxt  = r_state;
        w_prev_nxt   = r_prev;
        w_enable_nxt = 1'b0;
        w_err_nxt    = 1'b0;
        w_dir_nxt    = r_up_down;
        w_pos_nxt    = r_pos;
        w_errc_nxt   = r_errc;
        case (r_state)
            S_INIT: begin
                if (w_init_load) begin
                    w_prev_nxt  = r_sync2;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_prev_nxt = w_filt;
                case ({r_prev, w_filt})
                    // Up: 00->01->11->10->00
                    4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
                        w_enable_nxt = 1'b1;
                        w_dir_nxt    = 1'b1;
                        w_pos_nxt    = r_pos + POS_W'(1);
                    end
                    // Down: 00->10->11->01->00
                    4'b0010, 4'b1011, 4'b1101, 4'b0100: begin
                        w_enable_nxt = 1'b1;
                        w_dir_nxt    = 1'b0;
                        w_pos_nxt    = r_pos - POS_W'(1);
                    end
                    // Both channels moved at once: direction is unknowable.
                    4'b0011, 4'b1100, 4'b0110, 4'b1001: begin
                        w_err_nxt = 1'b1;
                        if (r_errc != 4'hF) begin
                            w_errc_nxt = r_errc + 4'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    assign enable   = r_enable;
    assign err      = r_err;
    assign up_down  = r_up_down;
    assign position = r_pos;
    assign err_cnt  = r_errc;

endmodule
`default_nettype wire

// File: tb/tb_quad_step_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_quad_step_decoder
//  Description : Randomized scoreboard bench for quad_step_decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_quad_step_decoder;

    localparam int FILTER_LEN = 4;
    localparam int POS_W      = 8;
    localparam int POS_MOD    = 1 << POS_W;
    // Input driven just after edge n is captured at n+1; pulse visible after n+1+FILTER_LEN+2.
    localparam int LAT        = FILTER_LEN + 3;

    logic             tb_clk = 1'b0;
    logic             rst    = 1'b0;
    logic             enc_a  = 1'b0;
    logic             enc_b  = 1'b0;
    logic             enable;
    logic             up_down;
    logic [POS_W-1:0] position;
    logic             err;
    logic [3:0]       err_cnt;

    quad_step_decoder #(
        .FILTER_LEN (FILTER_LEN),
        .POS_W      (POS_W)
    ) dut (
        .clk      (tb_clk),
        .rst      (rst),
        .enc_a    (enc_a),
        .enc_b    (enc_b),
        .enable   (enable),
        .up_down  (up_down),
        .position (position),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    always #5 tb_clk = ~tb_clk;

    int cyc = 0;
    always @(posedge tb_clk) cyc <= cyc + 1;

    typedef struct {
        int               cyc;
        bit               is_err;
        bit               dir;
        logic [POS_W-1:0] pos;
        logic [3:0]       errc;
    } ev_t;

    ev_t sb[$];
    bit  done = 1'b0;

    // Reference model: encoder position on the Gray cycle 00,01,11,10.
    bit [1:0] m_ab   = 2'b00;
    int       m_pos  = 0;
    bit       m_dir  = 1'b0;
    int       m_errc = 0;

    function automatic int gidx(input bit [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic drive(input bit [1:0] ab, input int hold);
        ev_t e;
        int  d;
        @(posedge tb_clk);
        #1;
        if (ab != m_ab) begin
            d = (gidx(ab) - gidx(m_ab) + 4) % 4;
            e.cyc = cyc + LAT;
            if (d == 2) begin
                e.is_err = 1'b1;
                if (m_errc < 15) m_errc++;
            end else begin
                e.is_err = 1'b0;
                m_dir = (d == 1);
                m_pos = (m_pos + ((d == 1) ? 1 : POS_MOD - 1)) % POS_MOD;
            end
            e.dir  = m_dir;
            e.pos  = POS_W'(m_pos);
            e.errc = 4'(m_errc);
            sb.push_back(e);
        end
        enc_a = ab[1];
        enc_b = ab[0];
        m_ab  = ab;
        repeat (hold - 1) @(posedge tb_clk);
    endtask

    // Pulse one channel away from its settled level for fewer than FILTER_LEN cycles.
    task automatic glitch(input bit ch_a, input int len);
        @(posedge tb_clk);
        #1;
        if (ch_a) enc_a = ~m_ab[1];
        else      enc_b = ~m_ab[0];
        repeat (len) @(posedge tb_clk);
        #1;
        enc_a = m_ab[1];
        enc_b = m_ab[0];
        repeat (5) @(posedge tb_clk);
    endtask

    task automatic do_reset();
        @(posedge tb_clk);
        #1;
        rst    = 1'b0;
        m_pos  = 0;
        m_dir  = 1'b0;
        m_errc = 0;
        repeat (3) @(posedge tb_clk);
        #1;
        rst = 1'b1;
        repeat (20) @(posedge tb_clk);
    endtask

    // Stimulus
    initial begin
        int r;
        repeat (3) @(posedge tb_clk);
        #1;
        rst = 1'b1;
        repeat (20) @(posedge tb_clk);

        // Full up cycle, then down past zero.
        drive(2'b01, 10); drive(2'b11, 10); drive(2'b10, 10); drive(2'b00, 10);
        drive(2'b10, 10); drive(2'b11, 10); drive(2'b01, 10); drive(2'b00, 10);
        drive(2'b10, 10);

        // Short pulses must be swallowed.
        glitch(1'b1, 3);
        glitch(1'b0, 3);
        glitch(1'b1, 1);

        // Illegal toggles up to and past saturation.
        for (int i = 0; i < 16; i++) drive(m_ab ^ 2'b11, 10);

        // Random walk with occasional glitches.
        for (int i = 0; i < 80; i++) begin
            r = int'($urandom_range(0, 4));
            if (r == 0) glitch(1'($urandom_range(0, 1)), int'($urandom_range(1, FILTER_LEN - 1)));
            else        drive(2'($urandom_range(0, 3)), int'($urandom_range(6, 12)));
        end

        // Reset while both channels high; state is adopted silently.
        drive(2'b11, 12);
        do_reset();
        drive(2'b01, 12);
        drive(2'b11, 12);

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge tb_clk);
        repeat (3) @(posedge tb_clk);
        done = 1'b1;
    end

    // Monitor / scoreboard
    int               checks   = 0;
    int               failures = 0;
    logic [POS_W-1:0] cur_pos  = '0;
    bit               cur_dir  = 1'b0;
    logic [3:0]       cur_errc = 4'd0;
    ev_t              ev;

    always @(negedge tb_clk) begin
        if (!rst) begin
            checks++;
            if (enable !== 1'b0 || err !== 1'b0 || up_down !== 1'b0 ||
                position !== '0 || err_cnt !== 4'd0) begin
                failures++;
                $display("FAIL reset_outputs: got en=%0b err=%0b dir=%0b pos=%0d errc=%0d, expected all 0",
                         enable, err, up_down, position, err_cnt);
            end
            cur_pos  = '0;
            cur_dir  = 1'b0;
            cur_errc = 4'd0;
        end else begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                ev = sb.pop_front();
                checks++;
                failures++;
                $display("FAIL missed_event: expected %s at cycle %0d, got no pulse by cycle %0d",
                         ev.is_err ? "err" : "step", ev.cyc, cyc);
                cur_pos  = ev.pos;
                cur_dir  = ev.dir;
                cur_errc = ev.errc;
            end
            if (enable === 1'b1 || err === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse: cycle %0d en=%0b err=%0b, expected no pulse",
                             cyc, enable, err);
                end else begin
                    ev = sb.pop_front();
                    if (ev.cyc != cyc || enable !== !ev.is_err || err !== ev.is_err ||
                        up_down !== ev.dir || position !== ev.pos || err_cnt !== ev.errc) begin
                        failures++;
                        $display("FAIL event: got cyc=%0d en=%0b err=%0b dir=%0b pos=%0d errc=%0d, expected cyc=%0d en=%0b err=%0b dir=%0b pos=%0d errc=%0d",
                                 cyc, enable, err, up_down, position, err_cnt,
                                 ev.cyc, !ev.is_err, ev.is_err, ev.dir, ev.pos, ev.errc);
                    end
                    cur_pos  = ev.pos;
                    cur_dir  = ev.dir;
                    cur_errc = ev.errc;
                end
            end
            checks++;
            if (position !== cur_pos || up_down !== cur_dir || err_cnt !== cur_errc) begin
                failures++;
                $display("FAIL level_hold: cycle %0d got pos=%0d dir=%0b errc=%0d, expected pos=%0d dir=%0b errc=%0d",
                         cyc, position, up_down, err_cnt, cur_pos, cur_dir, cur_errc);
            end
        end
        if (done) begin
            checks++;
            if (sb.size() != 0) begin
                failures++;
                $display("FAIL leftover_events: got %0d pending, expected 0", sb.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    // Absolute time limit in case the stimulus never completes.
    initial begin
        #2000000;
        $display("FAIL timeout: got no completion by %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
